// File: rtl/alu_muldiv_control.sv
// Multiply/divide control unit beside the EX-stage ALU.
// Decodes R-type HI/LO move and MULT/MULTU/DIV/DIVU funct codes, runs an
// iterative shift-add multiplier / restoring divider, and holds HI/LO.
// Ports:
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   alu_op_i              main-control ALU op (2'b10 = R-type)
//   funct_field_i         instruction funct field
//   valid_i               instruction present in EX
//   a_i, b_i              rs / rt operands
//   busy_o                operation in flight (stall request)
//   done_o                one-cycle pulse when MULT/DIV writes HI/LO
//   div_by_zero_o         pulse with done_o on divide by zero
//   hi_o, lo_o            architectural HI/LO registers
//   result_o              MFHI/MFLO read value (combinational)
module alu_muldiv_control #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned FUNCT_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [1:0]             alu_op_i,
    input  logic [FUNCT_WIDTH-1:0] funct_field_i,
    input  logic                   valid_i,
    input  logic [WIDTH-1:0]       a_i,
    input  logic [WIDTH-1:0]       b_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   div_by_zero_o,
    output logic [WIDTH-1:0]       hi_o,
    output logic [WIDTH-1:0]       lo_o,
    output logic [WIDTH-1:0]       result_o
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [1:0]             ALU_RTYPE = 2'b10;
    localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = FUNCT_WIDTH'('h10);
    localparam logic [FUNCT_WIDTH-1:0] F_MTHI  = FUNCT_WIDTH'('h11);
    localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = FUNCT_WIDTH'('h12);
    localparam logic [FUNCT_WIDTH-1:0] F_MTLO  = FUNCT_WIDTH'('h13);
    localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'('h18);
    localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'('h19);
    localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'('h1A);
    localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'('h1B);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;       // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   op_q, op_d;         // |multiplicand| or |divisor|
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic               accept, is_signed, a_neg, b_neg, last, q_bit;
    logic [WIDTH-1:0]   a_abs, b_abs, mul_add, quo, rem;
    logic [WIDTH:0]     mul_sum, div_top;
    logic [WIDTH+1:0]   div_diff;
    logic [ACC_W-1:0]   prod;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            op_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // Next-state, iteration step and sign correction
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        op_d      = op_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_add   = '0;
        mul_sum   = '0;
        div_top   = '0;
        div_diff  = '0;
        q_bit     = 1'b0;
        prod      = '0;
        quo       = '0;
        rem       = '0;

        accept    = valid_i && (alu_op_i == ALU_RTYPE) && (state_q == S_IDLE);
        is_signed = (funct_field_i == F_MULT) || (funct_field_i == F_DIV);
        a_neg     = is_signed && a_i[WIDTH-1];
        b_neg     = is_signed && b_i[WIDTH-1];
        a_abs     = a_neg ? (~a_i + WIDTH'(1)) : a_i;
        b_abs     = b_neg ? (~b_i + WIDTH'(1)) : b_i;
        last      = (cnt_q == CNT_W'(WIDTH - 1));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (funct_field_i)
                        F_MTHI: hi_d = a_i;
                        F_MTLO: lo_d = a_i;
                        F_MULT, F_MULTU: begin
                            state_d   = S_MUL;
                            cnt_d     = '0;
                            acc_d     = {WIDTH'(0), b_abs};
                            op_d      = a_abs;
                            is_div_d  = 1'b0;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            zero_d    = 1'b0;
                        end
                        F_DIV, F_DIVU: begin
                            state_d   = S_DIV;
                            cnt_d     = '0;
                            acc_d     = {WIDTH'(0), a_abs};
                            op_d      = b_abs;
                            is_div_d  = 1'b1;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            zero_d    = (b_i == '0);
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                // Add multiplicand into upper half when multiplier LSB set, then shift right
                mul_add = acc_q[0] ? op_q : '0;
                mul_sum = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, mul_add};
                acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) state_d = S_FIX;
            end
            S_DIV: begin
                // Shift remainder in, trial-subtract; no borrow means quotient bit 1
                div_top  = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
                div_diff = {1'b0, div_top} - {2'b00, op_q};
                q_bit    = ~div_diff[WIDTH+1];
                // Divide by zero keeps the latched dividend for HI
                if (!zero_q) begin
                    acc_d = {(q_bit ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], q_bit};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!is_div_q) begin
                    prod = neg_res_q ? (~acc_q + ACC_W'(1)) : acc_q;
                    hi_d = prod[ACC_W-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (zero_q) begin
                    // Re-apply the dividend sign to recover the original a_i
                    hi_d = neg_rem_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
                    lo_d = '1;
                end else begin
                    quo  = acc_q[WIDTH-1:0];
                    rem  = acc_q[ACC_W-1:WIDTH];
                    lo_d = neg_res_q ? (~quo + WIDTH'(1)) : quo;
                    hi_d = neg_rem_q ? (~rem + WIDTH'(1)) : rem;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        dbz_d  = (state_d == S_DONE) && zero_q;
    end

    // MFHI/MFLO read port
    always_comb begin
        result_o = '0;
        if (valid_i && (alu_op_i == ALU_RTYPE)) begin
            if (funct_field_i == F_MFHI)      result_o = hi_q;
            else if (funct_field_i == F_MFLO) result_o = lo_q;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Scoreboard bench for alu_muldiv_control: stimulus pushes expected HI/LO/
// div-by-zero per MULT/DIV; a monitor pops and compares on every done_o.
module tb_alu_muldiv_control;
    localparam int unsigned W  = 32;
    localparam int unsigned FW = 6;

    localparam logic [FW-1:0] F_MFHI  = 6'h10;
    localparam logic [FW-1:0] F_MFLO  = 6'h12;
    localparam logic [FW-1:0] F_MTLO  = 6'h13;
    localparam logic [FW-1:0] F_MULT  = 6'h18;
    localparam logic [FW-1:0] F_MULTU = 6'h19;
    localparam logic [FW-1:0] F_DIV   = 6'h1A;
    localparam logic [FW-1:0] F_DIVU  = 6'h1B;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [1:0]    alu_op_i;
    logic [FW-1:0] funct_field_i;
    logic          valid_i;
    logic [W-1:0]  a_i, b_i;
    logic          busy_o, done_o, div_by_zero_o;
    logic [W-1:0]  hi_o, lo_o, result_o;

    alu_muldiv_control #(.WIDTH(W), .FUNCT_WIDTH(FW)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .alu_op_i      (alu_op_i),
        .funct_field_i (funct_field_i),
        .valid_i       (valid_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .result_o      (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every done_o consumes one scoreboard entry
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (done_o) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", W'(done_o), W'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_hi", hi_o, e.hi);
                    chk("sb_lo", lo_o, e.lo);
                    chk("sb_dbz", W'(div_by_zero_o), W'(e.dbz));
                end
            end else if (div_by_zero_o) begin
                chk("dbz_without_done", W'(div_by_zero_o), W'(0));
            end
        end
    end

    // Issue one MULT/DIV and track busy/done timing
    task automatic run_op(input string nm, input logic [FW-1:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edbz, input bit hold, input bit mt_busy);
        int done_cyc = 0;
        int busy_bad = 0;
        logic [W-1:0] lo_before;
        sb_q.push_back('{ehi, elo, edbz});
        @(negedge clk_i);
        valid_i = 1'b1; alu_op_i = 2'b10; funct_field_i = f; a_i = a; b_i = b;
        lo_before = lo_o;
        @(posedge clk_i);
        #1;
        if (!hold) valid_i = 1'b0;
        for (int cyc = 1; cyc <= int'(W) + 8 && done_cyc == 0; cyc++) begin
            @(negedge clk_i);
            if (busy_o !== 1'b1) busy_bad++;
            if (done_o === 1'b1) begin
                done_cyc = cyc;
                valid_i = 1'b0;
            end
            if (mt_busy && cyc == 5) begin
                valid_i = 1'b1; funct_field_i = F_MTLO; a_i = 32'h0000_1234;
            end
            if (mt_busy && cyc == 6) begin
                chk({nm, "_lo_during_busy"}, lo_o, lo_before);
                valid_i = 1'b0; funct_field_i = f; a_i = a;
            end
        end
        chk({nm, "_done_cycle"}, W'(done_cyc), W'(W + 2));
        chk({nm, "_busy_gaps"}, W'(busy_bad), W'(0));
        @(negedge clk_i);
        chk({nm, "_busy_after"}, W'(busy_o), W'(0));
    endtask

    initial begin
        valid_i = 1'b0; alu_op_i = 2'b00; funct_field_i = '0; a_i = '0; b_i = '0;
        #2;
        chk("rst_busy", W'(busy_o), W'(0));
        chk("rst_done", W'(done_o), W'(0));
        chk("rst_hi", hi_o, '0);
        chk("rst_lo", lo_o, '0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0);

        // MFHI / MFLO reads are combinational and never stall
        valid_i = 1'b1; alu_op_i = 2'b10; funct_field_i = F_MFHI;
        #1;
        chk("mfhi_result", result_o, 32'hFFFF_FFFF);
        funct_field_i = F_MFLO;
        #1;
        chk("mflo_result", result_o, 32'hFFFF_FFF1);
        @(posedge clk_i);
        #1;
        chk("mf_no_busy", W'(busy_o), W'(0));
        valid_i = 1'b0;

        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_op("divu", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0, 1'b0);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run_op("divu_zero", F_DIVU, 32'd5, 32'd0,
               32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("mult_hold", F_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b1, 1'b0);
        run_op("multu_mtlo_busy", F_MULTU, 32'h0001_0000, 32'h0001_0000,
               32'd1, 32'd0, 1'b0, 1'b0, 1'b1);

        // MTLO in IDLE
        @(negedge clk_i);
        valid_i = 1'b1; alu_op_i = 2'b10; funct_field_i = F_MTLO; a_i = 32'h0000_1234;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("mtlo_idle_lo", lo_o, 32'h0000_1234);
        chk("mtlo_idle_busy", W'(busy_o), W'(0));

        // Non-R-type op with MULT funct does nothing
        @(negedge clk_i);
        valid_i = 1'b1; alu_op_i = 2'b00; funct_field_i = F_MULT; a_i = 32'd7; b_i = 32'd6;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("aluop00_busy", W'(busy_o), W'(0));
        repeat (W + 4) @(negedge clk_i);
        chk("aluop00_lo", lo_o, 32'h0000_1234);

        // Reset in the middle of a MULT
        @(negedge clk_i);
        valid_i = 1'b1; alu_op_i = 2'b10; funct_field_i = F_MULT; a_i = 32'd7; b_i = 32'd6;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("pre_rst_busy", W'(busy_o), W'(1));
        #1 rst_n_i = 1'b0;
        #1;
        chk("mid_rst_busy", W'(busy_o), W'(0));
        chk("mid_rst_hi", hi_o, '0);
        chk("mid_rst_lo", lo_o, '0);
        chk("mid_rst_done", W'(done_o), W'(0));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (W + 4) @(negedge clk_i);
        chk("post_rst_busy", W'(busy_o), W'(0));
        valid_i = 1'b1; alu_op_i = 2'b10; funct_field_i = F_MTLO; a_i = 32'h0000_0055;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_mtlo", lo_o, 32'h0000_0055);

        chk("sb_empty", W'(sb_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
